sc_time_controller: RTL
=======================

# sc_time_controller

Sequencer for the game-time up-counter (`SC_RegGENERAL_Time`).
- Derives a 1-per-period count enable from the 50 MHz clock with an internal prescaler.
- Runs a start/pause/stop/timeout state machine.
- Drives the counter's active-low upcount input and its active-high reset input.
- Watches the counter value fed back to it and stops counting at a configurable limit.

## Interface
- `RegGENERAL_DATAWIDTH`, 8, width of the time counter value.
- `PRESCALE_WIDTH`, 26, width of the internal prescaler.
- `PRESCALE_TERMINAL`, 49999999, last prescaler value before a tick. Must be ≥ 2.
- `TIME_LIMIT`, 99, counter value that ends a run.
- `SC_RegGENERAL_Time_CLOCK_50`  in  1  system clock.
- `SC_RegGENERAL_Time_RESET_InHigh`  in  1  reset, asynchronous, active-high.
- `start_InHigh`  in  1  one-cycle start/resume request.
- `pause_InHigh`  in  1  one-cycle pause/resume toggle request.
- `stop_InHigh`  in  1  one-cycle stop request.
- `time_data_InBUS`  in  RegGENERAL_DATAWIDTH  counter value feedback.
- `upcount_OutLow`  out  1  to counter upcount input; low for one cycle per tick.
- `counter_reset_OutHigh`  out  1  to counter reset input; one-cycle clear pulse.
- `timeout_OutHigh`  out  1  high while in TIMEOUT.
- `state_OutBUS`  out  2  current state encoding.

## Operation
- States:
  - IDLE = 00
  - RUN = 01
  - PAUSE = 10
  - TIMEOUT = 11
- All outputs are registered.
- Reset values: state IDLE, prescaler 0, `upcount_OutLow` = 1, `counter_reset_OutHigh` = 0, `timeout_OutHigh` = 0, `state_OutBUS` = 00.
- Request priority in every state: stop > limit check > pause > start.
- IDLE:
  - start → RUN, prescaler ← 0, `counter_reset_OutHigh` = 1 for the first RUN cycle.
  - pause and stop are ignored.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler == PRESCALE_TERMINAL: prescaler ← 0 and `upcount_OutLow` ← 0 for exactly one cycle (the tick).
  - stop → IDLE. The counter is not cleared, so the final time stays displayed.
  - `time_data_InBUS` == TIME_LIMIT → TIMEOUT; the tick in that cycle is suppressed.
  - pause → PAUSE; the prescaler holds its value.
  - start is ignored.
- Limit compare masking: the compare is disabled while `counter_reset_OutHigh` = 1, so a stale value cannot cause an immediate timeout.
- PAUSE:
  - No ticks; prescaler holds.
  - pause or start → RUN, resuming from the held prescaler value with no counter clear.
  - stop → IDLE.
- TIMEOUT:
  - No ticks; `timeout_OutHigh` = 1.
  - start → RUN with clear pulse and prescaler ← 0.
  - stop → IDLE; `timeout_OutHigh` falls the same edge.
  - pause is ignored.
- Prescaler arithmetic: unsigned, width PRESCALE_WIDTH. It never exceeds PRESCALE_TERMINAL (wraps to 0).

## Timing
- Request inputs are sampled on the rising edge; the state changes on that same edge.
- Tick timing:
  - With RUN entered at edge E0, the first tick is registered at E(T+1), where T = PRESCALE_TERMINAL.
  - `upcount_OutLow` is low from E(T+1) to E(T+2), and the counter increments at E(T+2).
  - Subsequent ticks follow every T+1 cycles.
- Clear pulse: `counter_reset_OutHigh` is high from the RUN-entry edge to the next edge.
- Limit detection is combinational on `time_data_InBUS`, so TIMEOUT is entered on the first edge where the value equals TIME_LIMIT.
- Because T ≥ 2, no tick is pending when the limit is reached and the counter never overshoots TIME_LIMIT.
- Reset mid-operation: asserting reset forces all outputs to their reset values immediately, even mid-tick or mid-clear. A tick in progress is dropped.

## Configuration
- `SC_TIME_PAUSE_EN` defined: PAUSE state and `pause_InHigh` behave as above.
- `SC_TIME_PAUSE_EN` undefined:
  - `pause_InHigh` is ignored and PAUSE is unreachable.
  - In RUN, start remains ignored; all other behaviour is identical.

## Test plan
Bench parameters: PRESCALE_TERMINAL = 3, TIME_LIMIT = 5; the bench models the counter.
- Reset, then start pulse → `state_OutBUS` = 01, `counter_reset_OutHigh` high 1 cycle, counter = 0, first `upcount_OutLow` low 4 cycles after entry, then every 4 cycles.
- Run to the limit → counter stops at 5, `state_OutBUS` = 11, `timeout_OutHigh` = 1, no further ticks over 20 cycles; start restarts from 0.
- Pause with prescaler = 2, hold 10 cycles, then pause again → no ticks while paused; next tick 2 cycles after resume; counter unchanged.
- Stop and start in the same cycle during RUN → IDLE, counter value retained, no clear pulse.
- Assert reset while `upcount_OutLow` = 0 → `upcount_OutLow` = 1 and state 00 immediately; the counter does not increment.
- Build without `SC_TIME_PAUSE_EN`, pause pulse in RUN → state stays 01 and the tick spacing is unchanged.

Source files
------------

// File: rtl/sc_time_controller.sv
// sc_time_controller
// Sequencer for the game-time up-counter (SC_RegGENERAL_Time). It derives a
// once-per-period tick from the 50 MHz clock with an internal prescaler. It
// runs the IDLE/RUN/PAUSE/TIMEOUT state machine and drives the counter's
// active-low upcount and active-high clear inputs. It watches the counter
// value fed back to it and stops counting at TIME_LIMIT.
// Optional feature macro: SC_TIME_PAUSE_EN (pause/resume support). When it is
// undefined, pause_InHigh is ignored and the PAUSE state is never entered.

module sc_time_controller #(
   parameter int RegGENERAL_DATAWIDTH = 8,
   parameter int PRESCALE_WIDTH       = 26,
   parameter int PRESCALE_TERMINAL    = 49999999,
   parameter int TIME_LIMIT           = 99
) (
   input  logic                            SC_RegGENERAL_Time_CLOCK_50,
   input  logic                            SC_RegGENERAL_Time_RESET_InHigh,
   input  logic                            start_InHigh,
   input  logic                            pause_InHigh,
   input  logic                            stop_InHigh,
   input  logic [RegGENERAL_DATAWIDTH-1:0] time_data_InBUS,
   output logic                            upcount_OutLow,
   output logic                            counter_reset_OutHigh,
   output logic                            timeout_OutHigh,
   output logic [1:0]                      state_OutBUS
);

   typedef enum logic [1:0] {
      StateIdle    = 2'b00,
      StateRun     = 2'b01,
      StatePause   = 2'b10,
      StateTimeout = 2'b11
   } stateT;

`ifdef SC_TIME_PAUSE_EN
   localparam bit PauseEnabled = 1'b1;
`else
   localparam bit PauseEnabled = 1'b0;
`endif

   localparam logic [PRESCALE_WIDTH-1:0]       PrescaleTerminal = PRESCALE_WIDTH'(PRESCALE_TERMINAL);
   localparam logic [RegGENERAL_DATAWIDTH-1:0] TimeLimit        = RegGENERAL_DATAWIDTH'(TIME_LIMIT);

   stateT                     r_state;
   logic [PRESCALE_WIDTH-1:0] r_prescaler;
   logic                      r_upcount;
   logic                      r_counterReset;
   logic                      r_timeout;

   logic                      w_limitHit;
   logic                      w_pauseReq;
   logic                      w_prescaleDone;

   // The limit compare is masked during the clear pulse. The counter still
   // shows the previous run's value then, and that value must not end the
   // new run at once. A pause request only exists when the feature is built in.
   always_comb begin
      w_limitHit     = (time_data_InBUS == TimeLimit) && !r_counterReset;
      w_pauseReq     = pause_InHigh && PauseEnabled;
      w_prescaleDone = (r_prescaler == PrescaleTerminal);
   end

   // Single state machine. The tick and clear pulses default low each cycle,
   // so they last exactly one cycle. Requests are taken in the order
   // stop, limit, pause, start.
   always_ff @(posedge SC_RegGENERAL_Time_CLOCK_50 or posedge SC_RegGENERAL_Time_RESET_InHigh) begin
      if (SC_RegGENERAL_Time_RESET_InHigh) begin
         r_state        <= StateIdle;
         r_prescaler    <= '0;
         r_upcount      <= 1'b1;
         r_counterReset <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_upcount      <= 1'b1;
         r_counterReset <= 1'b0;
         case (r_state)
            StateIdle: begin
               if (!stop_InHigh && start_InHigh) begin
                  r_state        <= StateRun;
                  r_prescaler    <= '0;
                  r_counterReset <= 1'b1;
               end
            end
            StateRun: begin
               if (stop_InHigh) begin
                  r_state <= StateIdle;
               end else if (w_limitHit) begin
                  r_state   <= StateTimeout;
                  r_timeout <= 1'b1;
               end else if (w_pauseReq) begin
                  r_state <= StatePause;
               end else if (w_prescaleDone) begin
                  r_prescaler <= '0;
                  r_upcount   <= 1'b0;
               end else begin
                  r_prescaler <= r_prescaler + 1'b1;
               end
            end
            StatePause: begin
               if (stop_InHigh) begin
                  r_state <= StateIdle;
               end else if (w_pauseReq || start_InHigh) begin
                  r_state <= StateRun;
               end
            end
            StateTimeout: begin
               if (stop_InHigh) begin
                  r_state   <= StateIdle;
                  r_timeout <= 1'b0;
               end else if (start_InHigh) begin
                  r_state        <= StateRun;
                  r_prescaler    <= '0;
                  r_counterReset <= 1'b1;
                  r_timeout      <= 1'b0;
               end
            end
            default: begin
               r_state <= StateIdle;
            end
         endcase
      end
   end

   assign upcount_OutLow        = r_upcount;
   assign counter_reset_OutHigh = r_counterReset;
   assign timeout_OutHigh       = r_timeout;
   assign state_OutBUS          = r_state;

endmodule
